// File: rtl/food_placer.sv
`default_nettype none
// ============================================================================
// Module   : food_placer
// Purpose  : Turns the free-running random X/Y stream into a free apple cell,
//            retrying random candidates, then scanning the grid row-major.
// Revision : 1.0 - initial release
// ============================================================================
module food_placer #(
    parameter int GRID_W    = 64,
    parameter int GRID_H    = 48,
    parameter int CELL      = 10,
    parameter int MAX_TRIES = 16
) (
    input  logic                      VGA_clk,
    input  logic                      reset,
    input  logic [9:0]                randX,
    input  logic [8:0]                randY,
    input  logic                      spawnReq,
    output logic                      chkValid,
    output logic [$clog2(GRID_W)-1:0] chkX,
    output logic [$clog2(GRID_H)-1:0] chkY,
    input  logic                      occupied,
    output logic [9:0]                appleX,
    output logic [8:0]                appleY,
    output logic                      appleValid,
    output logic                      spawnDone,
    output logic                      busy,
    output logic                      gridFull
);

    localparam int XB     = $clog2(GRID_W);
    localparam int YB     = $clog2(GRID_H);
    localparam int NCELLS = GRID_W * GRID_H;
    localparam int SB     = $clog2(NCELLS + 1);
    localparam int TB     = $clog2(MAX_TRIES + 1);

    localparam logic [XB-1:0] C_X_LAST   = XB'(GRID_W - 1);
    localparam logic [YB-1:0] C_Y_LAST   = YB'(GRID_H - 1);
    localparam logic [TB-1:0] C_TRIES    = TB'(MAX_TRIES);
    localparam logic [SB-1:0] C_SCAN_END = SB'(NCELLS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_CHECK  = 3'd2,
        S_WAIT   = 3'd3,
        S_SCAN   = 3'd4,
        S_FULL   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [TB-1:0]   tries_q, tries_d;
    logic [SB-1:0]   scan_cnt_q, scan_cnt_d;
    logic            scan_mode_q, scan_mode_d;
    logic [XB-1:0]   cand_x_q, cand_x_d;
    logic [YB-1:0]   cand_y_q, cand_y_d;
    logic            chk_valid_q, chk_valid_d;
    logic [XB-1:0]   chk_x_q, chk_x_d;
    logic [YB-1:0]   chk_y_q, chk_y_d;
    logic [9:0]      apple_x_q, apple_x_d;
    logic [8:0]      apple_y_q, apple_y_d;
    logic            apple_valid_q, apple_valid_d;
    logic            spawn_done_q, spawn_done_d;
    logic            busy_q, busy_d;
    logic            grid_full_q, grid_full_d;

    logic [XB-1:0]   w_rx;
    logic [YB-1:0]   w_ry;
    logic            w_in_range;
    logic [TB-1:0]   w_tries_inc;
    logic [XB-1:0]   w_next_x;
    logic [YB-1:0]   w_next_y;
    logic            w_unused_rand;

    // Only the low bits of the random words select a cell.
    assign w_rx          = randX[XB-1:0];
    assign w_ry          = randY[YB-1:0];
    assign w_unused_rand = ^{randX, randY};
    assign w_in_range    = (32'(w_rx) < GRID_W) && (32'(w_ry) < GRID_H);
    assign w_tries_inc   = tries_q + TB'(1);

    always_comb begin
        w_next_x = cand_x_q + XB'(1);
        w_next_y = cand_y_q;
        if (cand_x_q == C_X_LAST) begin
            w_next_x = '0;
            w_next_y = (cand_y_q == C_Y_LAST) ? '0 : cand_y_q + YB'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        tries_d       = tries_q;
        scan_cnt_d    = scan_cnt_q;
        scan_mode_d   = scan_mode_q;
        cand_x_d      = cand_x_q;
        cand_y_d      = cand_y_q;
        chk_valid_d   = chk_valid_q;
        chk_x_d       = chk_x_q;
        chk_y_d       = chk_y_q;
        apple_x_d     = apple_x_q;
        apple_y_d     = apple_y_q;
        apple_valid_d = apple_valid_q;
        spawn_done_d  = 1'b0;
        busy_d        = busy_q;
        grid_full_d   = grid_full_q;

        case (state_q)
            S_IDLE, S_FULL: begin
                if (spawnReq) begin
                    apple_valid_d = 1'b0;
                    busy_d        = 1'b1;
                    grid_full_d   = 1'b0;
                    tries_d       = '0;
                    scan_mode_d   = 1'b0;
                    scan_cnt_d    = '0;
                    state_d       = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                cand_x_d = w_rx;
                cand_y_d = w_ry;
                if (!w_in_range) begin
                    tries_d = w_tries_inc;
                    if (w_tries_inc == C_TRIES) begin
                        cand_x_d = C_X_LAST;
                        cand_y_d = C_Y_LAST;
                        state_d  = S_SCAN;
                    end
                end else begin
                    chk_valid_d = 1'b1;
                    chk_x_d     = w_rx;
                    chk_y_d     = w_ry;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                chk_valid_d = 1'b0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (!occupied) begin
                    apple_x_d     = 10'(32'(cand_x_q) * CELL);
                    apple_y_d     = 9'(32'(cand_y_q) * CELL);
                    apple_valid_d = 1'b1;
                    spawn_done_d  = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = S_IDLE;
                end else if (scan_mode_q) begin
                    state_d = S_SCAN;
                end else begin
                    tries_d = w_tries_inc;
                    if (w_tries_inc == C_TRIES) begin
                        // Park on the last cell so the scan's first step lands on (0,0).
                        cand_x_d = C_X_LAST;
                        cand_y_d = C_Y_LAST;
                        state_d  = S_SCAN;
                    end else begin
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_SCAN: begin
                scan_mode_d = 1'b1;
                if (scan_cnt_q == C_SCAN_END) begin
                    grid_full_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_FULL;
                end else begin
                    cand_x_d    = w_next_x;
                    cand_y_d    = w_next_y;
                    chk_x_d     = w_next_x;
                    chk_y_d     = w_next_y;
                    scan_cnt_d  = scan_cnt_q + SB'(1);
                    chk_valid_d = 1'b1;
                    state_d     = S_CHECK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tries_q       <= '0;
            scan_cnt_q    <= '0;
            scan_mode_q   <= 1'b0;
            cand_x_q      <= '0;
            cand_y_q      <= '0;
            chk_valid_q   <= 1'b0;
            chk_x_q       <= '0;
            chk_y_q       <= '0;
            apple_x_q     <= '0;
            apple_y_q     <= '0;
            apple_valid_q <= 1'b0;
            spawn_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            grid_full_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tries_q       <= tries_d;
            scan_cnt_q    <= scan_cnt_d;
            scan_mode_q   <= scan_mode_d;
            cand_x_q      <= cand_x_d;
            cand_y_q      <= cand_y_d;
            chk_valid_q   <= chk_valid_d;
            chk_x_q       <= chk_x_d;
            chk_y_q       <= chk_y_d;
            apple_x_q     <= apple_x_d;
            apple_y_q     <= apple_y_d;
            apple_valid_q <= apple_valid_d;
            spawn_done_q  <= spawn_done_d;
            busy_q        <= busy_d;
            grid_full_q   <= grid_full_d;
        end
    end

    assign chkValid   = chk_valid_q;
    assign chkX       = chk_x_q;
    assign chkY       = chk_y_q;
    assign appleX     = apple_x_q;
    assign appleY     = apple_y_q;
    assign appleValid = apple_valid_q;
    assign spawnDone  = spawn_done_q;
    assign busy       = busy_q;
    assign gridFull   = grid_full_q;

endmodule
`default_nettype wire

// File: tb/tb_food_placer.sv
`default_nettype none
// ============================================================================
// Module   : tb_food_placer
// Purpose  : Randomized self-checking bench for food_placer against a
//            transaction-level placement model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_food_placer;

    localparam int GRID_W    = 64;
    localparam int GRID_H    = 48;
    localparam int CELL      = 10;
    localparam int MAX_TRIES = 16;
    localparam int XB        = $clog2(GRID_W);
    localparam int YB        = $clog2(GRID_H);
    localparam int NC        = GRID_W * GRID_H;
    localparam int NR        = 10000;

    logic          VGA_clk = 1'b0;
    logic          reset;
    logic [9:0]    randX;
    logic [8:0]    randY;
    logic          spawnReq;
    logic          chkValid;
    logic [XB-1:0] chkX;
    logic [YB-1:0] chkY;
    logic          occupied;
    logic [9:0]    appleX;
    logic [8:0]    appleY;
    logic          appleValid;
    logic          spawnDone;
    logic          busy;
    logic          gridFull;

    food_placer #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .CELL(CELL), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .VGA_clk(VGA_clk), .reset(reset), .randX(randX), .randY(randY),
        .spawnReq(spawnReq), .chkValid(chkValid), .chkX(chkX), .chkY(chkY),
        .occupied(occupied), .appleX(appleX), .appleY(appleY),
        .appleValid(appleValid), .spawnDone(spawnDone), .busy(busy),
        .gridFull(gridFull)
    );

    always #5 VGA_clk = ~VGA_clk;

    int n_vec = 0;
    int n_err = 0;

    bit         occ [GRID_W][GRID_H];
    logic [9:0] rx  [NR];
    logic [8:0] ry  [NR];

    int exp_end;
    bit exp_full;
    int exp_cx, exp_cy;
    int exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Placement outcome from the rules: random tries, then a row-major scan from (0,0).
    // Edge numbers are relative to the edge that samples spawnReq (edge 0).
    task automatic model_predict();
        int t, tries, x, y;
        exp_q.delete();
        exp_full = 0;
        t = 1;
        tries = 0;
        while (tries < MAX_TRIES) begin
            x = int'(rx[t]) % (1 << XB);
            y = int'(ry[t]) % (1 << YB);
            if (x >= GRID_W || y >= GRID_H) begin
                tries++;
                t++;
            end else begin
                exp_q.push_back(x * 256 + y);
                if (!occ[x][y]) begin
                    exp_end = t + 2; exp_cx = x; exp_cy = y;
                    return;
                end
                tries++;
                t += 3;
            end
        end
        for (int i = 0; i < NC; i++) begin
            x = i % GRID_W;
            y = i / GRID_W;
            exp_q.push_back(x * 256 + y);
            if (!occ[x][y]) begin
                exp_end = t + 2; exp_cx = x; exp_cy = y;
                return;
            end
            t += 3;
        end
        exp_full = 1;
        exp_end  = t;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NR; k++) begin
            rx[k] = 10'($urandom);
            ry[k] = 9'($urandom);
        end
    endtask

    task automatic fill_occ(input int dens);
        for (int x = 0; x < GRID_W; x++)
            for (int y = 0; y < GRID_H; y++)
                occ[x][y] = ($urandom_range(99) < dens);
    endtask

    task automatic run_spawn(input int extra_k);
        int  e, ek;
        bit  p1v, p2v;
        int  p1x, p1y, p2x, p2y;
        model_predict();
        ek = (extra_k <= exp_end) ? extra_k : 0;
        @(negedge VGA_clk);
        spawnReq = 1'b1;
        randX = 10'($urandom);
        randY = 9'($urandom);
        occupied = 1'($urandom);
        @(posedge VGA_clk);
        p1v = 0; p2v = 0; p1x = 0; p1y = 0; p2x = 0; p2y = 0;
        for (int k = 1; k <= exp_end + 1; k++) begin
            @(negedge VGA_clk);
            spawnReq = (k == ek);
            randX = rx[k];
            randY = ry[k];
            occupied = p2v ? occ[p2x][p2y] : 1'($urandom);
            @(posedge VGA_clk);
            #1;
            check("spawnDone", 32'(spawnDone), 32'(k == exp_end && !exp_full));
            if (k == 1) begin
                check("busy_start", 32'(busy), 1);
                check("gridFull_start", 32'(gridFull), 0);
                check("appleValid_start", 32'(appleValid), 0);
            end
            if (k == exp_end) begin
                check("gridFull_edge", 32'(gridFull), 32'(exp_full));
                check("busy_end", 32'(busy), 0);
            end
            if (chkValid) begin
                if (exp_q.size() == 0) begin
                    check("extraQuery", 32'(chkValid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("chkX", 32'(chkX), 32'(e >> 8));
                    check("chkY", 32'(chkY), 32'(e & 255));
                end
            end
            p2v = p1v; p2x = p1x; p2y = p1y;
            p1v = chkValid; p1x = int'(chkX); p1y = int'(chkY);
        end
        check("missingQueries", 32'(exp_q.size()), 0);
        check("busy_after", 32'(busy), 0);
        check("gridFull", 32'(gridFull), 32'(exp_full));
        check("appleValid", 32'(appleValid), 32'(!exp_full));
        if (!exp_full) begin
            check("appleX", 32'(appleX), 32'(exp_cx * CELL));
            check("appleY", 32'(appleY), 32'(exp_cy * CELL));
        end
        @(negedge VGA_clk);
        spawnReq = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_chkValid"}, 32'(chkValid), 0);
        check({tag, "_chkX"}, 32'(chkX), 0);
        check({tag, "_chkY"}, 32'(chkY), 0);
        check({tag, "_appleX"}, 32'(appleX), 0);
        check({tag, "_appleY"}, 32'(appleY), 0);
        check({tag, "_appleValid"}, 32'(appleValid), 0);
        check({tag, "_spawnDone"}, 32'(spawnDone), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_gridFull"}, 32'(gridFull), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int dens_tab [4] = '{0, 30, 70, 97};
        reset = 1'b1; spawnReq = 1'b0; randX = '0; randY = '0; occupied = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge VGA_clk);
        @(negedge VGA_clk);
        reset = 1'b0;

        // Free first candidate (5,7).
        fill_occ(0); fill_rand();
        rx[1] = {4'($urandom), 6'd5};
        ry[1] = {3'($urandom), 6'd7};
        run_spawn(0);

        // Out-of-range Y first, then (2,3).
        fill_rand();
        rx[1] = {4'($urandom), 6'd9};
        ry[1] = {3'($urandom), 6'd50};
        rx[2] = {4'($urandom), 6'd2};
        ry[2] = {3'($urandom), 6'd3};
        run_spawn(0);

        // Fallback scan: only (3,0) is free and no random candidate hits it.
        fill_occ(100);
        occ[3][0] = 1'b0;
        fill_rand();
        for (int k = 0; k < NR; k++) begin
            ry[k] = {3'($urandom), 6'($urandom_range(GRID_H - 1))};
            if (rx[k][5:0] == 6'd3 && ry[k][5:0] == 6'd0) rx[k][5:0] = 6'd4;
        end
        run_spawn(0);

        // Completely full grid, then a new request from FULL onto an empty grid.
        fill_occ(100); fill_rand();
        run_spawn(0);
        fill_occ(0); fill_rand();
        run_spawn(0);

        // Requests while busy are ignored.
        fill_occ(50); fill_rand();
        run_spawn(2);
        fill_occ(97); fill_rand();
        run_spawn(40);

        // Asynchronous reset while waiting for the occupancy answer.
        fill_occ(0); fill_rand();
        @(negedge VGA_clk);
        spawnReq = 1'b1;
        @(posedge VGA_clk);
        @(negedge VGA_clk);
        spawnReq = 1'b0;
        randX = {4'($urandom), 6'd12};
        randY = {3'($urandom), 6'd20};
        @(posedge VGA_clk);
        @(posedge VGA_clk);
        #2 reset = 1'b1;
        #1;
        check_all_zero("midReset");
        @(negedge VGA_clk);
        reset = 1'b0;
        fill_rand();
        run_spawn(0);

        // Randomized transactions across occupancy densities.
        for (int n = 0; n < 12; n++) begin
            fill_occ(dens_tab[n % 4]);
            fill_rand();
            run_spawn($urandom_range(60, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
